serial_frame_receiver: RTL and testbench

Downstream consumer of the SISO shift-register stage. Takes its one-bit-per-cycle serial output, hunts for a sync pattern, deserializes the following DATA_W bits MSB-first, and optionally checks a trailing even-parity bit. Accepted words go into a 2-entry output buffer and are presented on a valid/ready parallel interface.

---
 rtl/serial_frame_receiver.sv | 140 ++++++++++++++
 tb/tb_serial_frame_receiver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: sync hunt, MSB-first deserializer, 2-entry output FIFO.
// Define SFR_PARITY_EN to expect and check a trailing even-parity bit per frame.
module serial_frame_receiver #(
  parameter int DATA_W = 8,
  parameter int SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [7:0]        par_err_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
`ifdef SFR_PARITY_EN
    PARITY = 2'd2,
`endif
    DATA = 2'd1
  } state_t;

  state_t              state_q;
  logic [SYNC_W-1:0]   sync_q;
  logic [DATA_W-1:0]   shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mem_q [2];
  logic                rd_q;
  logic [1:0]          fcnt_q;
  logic                overflow_q;

  logic [SYNC_W-1:0]   win_d;
  logic [DATA_W-1:0]   shift_d;
  logic [DATA_W-1:0]   word_d;
  logic                last_d;
  logic                commit_d;
  logic                pop_d;
  logic                full_d;
  logic                push_d;
  logic                ovf_d;
  logic                wr_idx_d;

`ifdef SFR_PARITY_EN
  logic [7:0]          par_q;
  logic                par_fail_d;
  assign par_err_cnt = par_q;
`else
  assign par_err_cnt = 8'd0;
`endif

  assign out_data  = mem_q[rd_q];
  assign out_valid = (fcnt_q != 2'd0);
  assign overflow  = overflow_q;

  always_comb begin
    win_d    = {sync_q[SYNC_W-2:0], bit_in};
    shift_d  = {shift_q[DATA_W-2:0], bit_in};
    last_d   = (cnt_q == CNT_W'(DATA_W - 1));
    word_d   = shift_d;
    commit_d = 1'b0;
`ifdef SFR_PARITY_EN
    par_fail_d = 1'b0;
    if (bit_valid && state_q == PARITY) begin
      word_d = shift_q;
      if (^{shift_q, bit_in}) par_fail_d = 1'b1;
      else                    commit_d   = 1'b1;
    end
`else
    if (bit_valid && state_q == DATA && last_d) commit_d = 1'b1;
`endif
    pop_d    = out_valid && out_ready;
    full_d   = (fcnt_q == 2'd2);
    push_d   = commit_d && (!full_d || pop_d);
    ovf_d    = commit_d && full_d && !pop_d;
    wr_idx_d = rd_q ^ fcnt_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      sync_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_q       <= 1'b0;
      fcnt_q     <= 2'd0;
      overflow_q <= 1'b0;
`ifdef SFR_PARITY_EN
      par_q      <= 8'd0;
`endif
    end else begin
      overflow_q <= ovf_d;
      if (push_d) mem_q[wr_idx_d] <= word_d;
      if (pop_d)  rd_q <= ~rd_q;
      fcnt_q <= fcnt_q + {1'b0, push_d} - {1'b0, pop_d};
      if (bit_valid) begin
        unique case (state_q)
          HUNT: begin
            // window restarts empty so a sync never borrows payload bits
            if (win_d == SYNC_PATTERN) begin
              state_q <= DATA;
              cnt_q   <= '0;
              sync_q  <= '0;
            end else begin
              sync_q  <= win_d;
            end
          end
          DATA: begin
            shift_q <= shift_d;
            if (last_d) begin
              cnt_q <= '0;
`ifdef SFR_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= HUNT;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef SFR_PARITY_EN
          PARITY: begin
            state_q <= HUNT;
            if (par_fail_d && par_q != 8'hFF) par_q <= par_q + 8'd1;
          end
`endif
          default: state_q <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver; parity steps follow SFR_PARITY_EN.
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic [7:0] par_err_cnt;

  int passed = 0;
  int total  = 0;
  logic [7:0] popped [$];

  serial_frame_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .par_err_cnt (par_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && out_valid && out_ready) popped.push_back(out_data);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_in    = v[n-1-i];
      bit_valid = 1'b1;
    end
  endtask

  task automatic send_slow(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_in    = v[n-1-i];
      bit_valid = 1'b1;
      @(negedge clk);
      bit_in    = 1'($urandom_range(0, 1));
      bit_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input logic par);
    send_bits(16'hB, 4);
    send_bits({8'h0, w}, 8);
`ifdef SFR_PARITY_EN
    send_bits({15'h0, par}, 1);
`else
    if (par) begin end
`endif
  endtask

  task automatic idle;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_perr", par_err_cnt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // basic frame, exactly one cycle of out_valid
    send_frame(8'hA5, 1'b0);
    idle();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'hA5);
    @(negedge clk);
    chk("t1_valid_fall", out_valid, 0);

    // sync preceded by noise that must not match early
    send_bits(16'h6B, 8);
    send_bits(16'h3C, 8);
`ifdef SFR_PARITY_EN
    send_bits(16'h0, 1);
`endif
    idle();
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 8'h3C);
    @(negedge clk);
    chk("t2_valid_fall", out_valid, 0);

    // overflow on third buffered word
    popped.delete();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33, 1'b0);
    idle();
    chk("t3_ovf", overflow, 1);
    chk("t3_head", out_data, 8'h11);
    @(negedge clk);
    chk("t3_ovf_fall", overflow, 0);
    chk("t3_hold", out_data, 8'h11);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_second", out_data, 8'h22);
    chk("t3_second_v", out_valid, 1);
    @(negedge clk);
    chk("t3_empty", out_valid, 0);
    chk("t3_npop", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("t3_pop0", popped[0], 8'h11);
      chk("t3_pop1", popped[1], 8'h22);
    end

    // bit_valid toggling with garbage in invalid cycles
    out_ready = 1'b0;
    send_slow(16'hB, 4);
`ifdef SFR_PARITY_EN
    send_slow(16'h5A, 8);
    chk("t4_early", out_valid, 0);
    send_slow(16'h0, 1);
`else
    send_slow(16'h2D, 7);
    chk("t4_early", out_valid, 0);
    send_slow(16'h0, 1);
`endif
    chk("t4_valid", out_valid, 1);
    chk("t4_data", out_data, 8'h5A);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_empty", out_valid, 0);

`ifdef SFR_PARITY_EN
    send_frame(8'hA5, 1'b0);
    idle();
    chk("t5_good_v", out_valid, 1);
    chk("t5_good_d", out_data, 8'hA5);
    send_frame(8'hA5, 1'b1);
    idle();
    chk("t5_bad_v", out_valid, 0);
    chk("t5_perr", par_err_cnt, 1);
`endif

    // reset mid-frame with a word buffered
    out_ready = 1'b0;
    send_frame(8'h77, 1'b0);
    send_bits(16'hB, 4);
    send_bits(16'hC, 4);
    @(negedge clk);
    bit_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_perr", par_err_cnt, 0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    popped.delete();
    send_frame(8'hC3, 1'b0);
    idle();
    chk("t6_valid", out_valid, 1);
    chk("t6_data", out_data, 8'hC3);
    repeat (3) @(negedge clk);
    chk("t6_empty", out_valid, 0);
    chk("t6_npop", popped.size(), 1);
    if (popped.size() == 1) chk("t6_pop", popped[0], 8'hC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
